// File: rtl/seq_pkg.sv
// Shared sequencer definitions: state encoding and control-byte bit positions.
// DATA_LEN defaults to 32 when the build does not define it.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

package seq_pkg;

    localparam int SEQ_DATA_LEN = `DATA_LEN;

    // Control byte occupies the top 8 bits of every instruction word
    localparam int CTL_R     = SEQ_DATA_LEN - 1;
    localparam int CTL_W     = SEQ_DATA_LEN - 2;
    localparam int CTL_ALU   = SEQ_DATA_LEN - 3;
    localparam int CTL_JMP   = SEQ_DATA_LEN - 4;
    localparam int CTL_IO    = SEQ_DATA_LEN - 5;
    localparam int CTL_IMM   = SEQ_DATA_LEN - 6;
    localparam int CTL_RESET = SEQ_DATA_LEN - 7;
    localparam int CTL_NEXT  = SEQ_DATA_LEN - 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT,
        ST_ERR,
        ST_PAUSE
    } seq_state_t;

    function automatic logic is_busy(seq_state_t s);
        return s inside {ST_REQ, ST_WAIT, ST_ISSUE, ST_EXEC, ST_PAUSE};
    endfunction

endpackage

// File: rtl/seq_wdog.sv
// Memory-wait watchdog: counts cycles while enabled, flags expiry on the
// MEM_TIMEOUT-th enabled cycle since the last clear.
module seq_wdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = en && (count_reg == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches one word per instruction, hands it to exec with
// valid/ready, and advances pc once exec_done. Optional SEQ_SINGLE_STEP_EN adds a step port.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_LEN    = SEQ_DATA_LEN,
    parameter int ADDR_W      = 8,
    parameter int START_ADDR  = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_req,
    input  logic                mem_rd_valid,
    input  logic [DATA_LEN-1:0] mem_data,
    output logic [DATA_LEN-1:0] instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                exec_done,
    input  logic                computation_end,
    output logic [ADDR_W-1:0]   pc,
    output logic [31:0]         instr_count,
    output logic                busy,
    output logic                halted,
    output logic                error
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic                step
`endif
);

    // Reset-flag position relative to this instance's word width
    localparam int RESET_BIT = CTL_RESET - SEQ_DATA_LEN + DATA_LEN;
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

    seq_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg;
    logic [DATA_LEN-1:0] instr_reg;
    logic [31:0]         count_reg;
    logic                mem_rd_req_reg, instr_valid_reg;
    logic                busy_reg, halted_reg, error_reg;
    logic                wdog_expired;
    logic [ADDR_W-1:0]   pc_next;

    seq_wdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_reg == ST_REQ),
        .en     (state_reg == ST_WAIT),
        .expired(wdog_expired)
    );

    assign pc_next = instr_reg[RESET_BIT] ? START_PC : pc_reg + ADDR_W'(1);

    always_comb begin
        state_next = state_reg;
        if (computation_end && (state_reg != ST_IDLE) && (state_reg != ST_ERR)) begin
            state_next = ST_HALT;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: if (start) state_next = ST_REQ;
                ST_REQ:           state_next = ST_WAIT;
                ST_WAIT: begin
                    // A word arriving on the expiry cycle still counts as a hit
                    if (mem_rd_valid)      state_next = ST_ISSUE;
                    else if (wdog_expired) state_next = ST_ERR;
                end
                ST_ISSUE:         if (instr_ready) state_next = ST_EXEC;
`ifdef SEQ_SINGLE_STEP_EN
                ST_EXEC:          if (exec_done) state_next = ST_PAUSE;
                ST_PAUSE:         if (step) state_next = ST_REQ;
`else
                ST_EXEC:          if (exec_done) state_next = ST_REQ;
`endif
                default:          state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= START_PC;
            instr_reg       <= '0;
            count_reg       <= '0;
            mem_rd_req_reg  <= 1'b0;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            halted_reg      <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_rd_req_reg  <= (state_next == ST_REQ);
            instr_valid_reg <= (state_next == ST_ISSUE);
            busy_reg        <= is_busy(state_next);
            halted_reg      <= (state_next == ST_HALT);
            error_reg       <= (state_next == ST_ERR);

            if ((state_reg == ST_IDLE || state_reg == ST_HALT) && state_next == ST_REQ) begin
                pc_reg    <= START_PC;
                count_reg <= '0;
            end
            if (state_reg == ST_WAIT && state_next == ST_ISSUE) begin
                instr_reg <= mem_data;
            end
            if (state_reg == ST_ISSUE && state_next == ST_EXEC) begin
                count_reg <= count_reg + 32'd1;
            end
            if (state_reg == ST_EXEC && (state_next == ST_REQ || state_next == ST_PAUSE)) begin
                pc_reg <= pc_next;
            end
        end
    end

    assign mem_addr    = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign instr_count = count_reg;
    assign mem_rd_req  = mem_rd_req_reg;
    assign instr_valid = instr_valid_reg;
    assign busy        = busy_reg;
    assign halted      = halted_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: tb acts as program memory and exec side,
// predicting addresses, words and counts from the fetch rules.
module tb_instr_sequencer;

    localparam int DL      = 32;
    localparam int AW      = 4;
    localparam int TMO     = 255;
    localparam int RST_BIT = DL - 7;

    logic          clk = 1'b0;
    logic          rst, start, mem_rd_valid, instr_ready, exec_done, computation_end;
    logic          mem_rd_req, instr_valid, busy, halted, error;
    logic [AW-1:0] mem_addr, pc;
    logic [DL-1:0] mem_data, instr;
    logic [31:0]   instr_count;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step;
`endif

    always #5 clk = ~clk;

    instr_sequencer #(
        .DATA_LEN   (DL),
        .ADDR_W     (AW),
        .START_ADDR (0),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem_addr       (mem_addr),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_valid   (mem_rd_valid),
        .mem_data       (mem_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .exec_done      (exec_done),
        .computation_end(computation_end),
        .pc             (pc),
        .instr_count    (instr_count),
        .busy           (busy),
        .halted         (halted),
        .error          (error)
`ifdef SEQ_SINGLE_STEP_EN
        ,
        .step           (step)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [DL-1:0] mem [16];
    logic [AW-1:0] exp_pc;
    logic [31:0]   exp_count;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            mem[i][RST_BIT] = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, 64'(mem_rd_req), 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_halted"}, 64'(halted), 64'd0);
        chk({tag, "_error"},  64'(error), 64'd0);
        chk({tag, "_req"},    64'(mem_rd_req), 64'd0);
        chk({tag, "_ivalid"}, 64'(instr_valid), 64'd0);
        chk({tag, "_pc"},     64'(pc), 64'd0);
        chk({tag, "_instr"},  64'(instr), 64'd0);
        chk({tag, "_count"},  64'(instr_count), 64'd0);
    endtask

    // One full fetch: md extra WAIT cycles, rd cycles before ready, dd cycles before done
    task automatic do_fetch(input int md, input int rd, input int dd);
        logic [DL-1:0] word;
        wait_req("fetch");
        chk("req_addr", 64'(mem_addr), 64'(exp_pc));
        chk("req_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("req_one_cycle", 64'(mem_rd_req), 64'd0);
        for (int i = 0; i < md; i++) begin
            if (instr_valid) chk("early_valid", 64'(instr_valid), 64'd0);
            @(negedge clk);
        end
        mem_rd_valid = 1'b1;
        mem_data     = mem[mem_addr];
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_data     = $urandom;
        word = mem[exp_pc];
        chk("instr_valid", 64'(instr_valid), 64'd1);
        chk("instr", 64'(instr), 64'(word));
        for (int i = 0; i < rd; i++) begin
            // Stray memory strobes and start pulses here must be ignored
            mem_rd_valid = 1'($urandom_range(0, 1));
            mem_data     = $urandom;
            start        = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_instr", 64'(instr), 64'(word));
        end
        mem_rd_valid = 1'b0;
        start        = 1'b0;
        instr_ready  = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        exp_count   = exp_count + 32'd1;
        chk("count", 64'(instr_count), 64'(exp_count));
        chk("valid_drop", 64'(instr_valid), 64'd0);
        for (int i = 0; i < dd; i++) begin
            chk("exec_no_req", 64'(mem_rd_req), 64'd0);
            @(negedge clk);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        exp_pc = word[RST_BIT] ? AW'(0) : exp_pc + AW'(1);
`ifdef SEQ_SINGLE_STEP_EN
        for (int i = 0; i < 3; i++) begin
            chk("pause_no_req", 64'(mem_rd_req), 64'd0);
            chk("pause_pc", 64'(pc), 64'(exp_pc));
            @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
`endif
        $display("fetch word=%08h count=%0d next_pc=%0d", word, exp_count, exp_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; mem_rd_valid = 1'b0; mem_data = '0;
        instr_ready = 1'b0; exec_done = 1'b0; computation_end = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        fill_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
        repeat (3) @(negedge clk);
        chk("idle_no_req", 64'(mem_rd_req), 64'd0);

        // Basic sequential fetch with immediate handshakes
        exp_pc = '0; exp_count = '0;
        pulse_start();
        for (int i = 0; i < 6; i++) do_fetch(0, 0, 0);

        // Randomized delays; runs past address 15 back to 0
        for (int i = 0; i < 10; i++)
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        chk("wrap_pc", 64'(exp_pc), 64'd0);
        chk("wrap_count", 64'(instr_count), 64'd16);

        // Long ready stall
        do_fetch(0, 10, 0);

        // Reset flag at address 5 sends the next fetch to address 0
        mem[5][RST_BIT] = 1'b1;
        while (exp_pc != AW'(6) && exp_pc != AW'(0) || exp_pc == AW'(1)) begin
            do_fetch($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            if (exp_pc == AW'(0)) break;
        end
        chk("reset_flag_pc", 64'(exp_pc), 64'd0);
        mem[5][RST_BIT] = 1'b0;
        do_fetch(0, 0, 0);

        // Memory answers on the last permitted WAIT cycle
        do_fetch(TMO - 1, 0, 0);

        // computation_end together with read data during WAIT
        wait_req("halt_wait");
        @(negedge clk);
        mem_rd_valid = 1'b1; mem_data = mem[mem_addr]; computation_end = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0; computation_end = 1'b0;
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("halt_no_valid", 64'(instr_valid), 64'd0);
            chk("halt_pc", 64'(pc), 64'(exp_pc));
            chk("halt_count", 64'(instr_count), 64'(exp_count));
            @(negedge clk);
        end
        exp_pc = '0; exp_count = '0;
        pulse_start();
        do_fetch(0, 0, 0);

        // computation_end on the accepting cycle: count must not move
        wait_req("halt_issue");
        @(negedge clk);
        mem_rd_valid = 1'b1; mem_data = mem[mem_addr];
        @(negedge clk);
        mem_rd_valid = 1'b0;
        instr_ready = 1'b1; computation_end = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0; computation_end = 1'b0;
        chk("halt2_flag", 64'(halted), 64'd1);
        chk("halt2_count", 64'(instr_count), 64'(exp_count));
        chk("halt2_pc", 64'(pc), 64'(exp_pc));
        exp_pc = '0; exp_count = '0;
        pulse_start();
        do_fetch(1, 1, 1);

        // Silent memory: error after MEM_TIMEOUT WAIT cycles
        wait_req("timeout");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!error && n < 400);
        chk("timeout_cycles", 64'(n), 64'(TMO + 1));
        chk("err_busy", 64'(busy), 64'd0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(error), 64'd1);
        chk("err_no_req", 64'(mem_rd_req), 64'd0);
        chk("err_pc", 64'(pc), 64'(exp_pc));
        $display("timeout error after %0d cycles", n);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_after_err");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
